axi_llc_miss_cnt_tracker: RTL and testbench
===========================================

# axi_llc_miss_cnt_tracker

Tracks outstanding miss descriptors per AXI ID and direction between the hit/miss unit and the merge unit. A count-up comes from the hit/miss unit when a descriptor enters the eviction/refill pipeline. A count-down comes from the merge unit's `cnt_down_o` when a descriptor leaves that pipeline. The hit/miss unit queries the tracker to hold back a bypass hit while older misses with the same ID and direction are still in flight, so per-ID AXI ordering holds across both paths.

## Interface
Parameters:
- `NumCnt`, 4: number of tracking entries (distinct ID/rw pairs in flight); ≥1.
- `CntWidth`, 4: per-entry counter width; max outstanding per entry = 2^CntWidth-1.
- `IdWidth`, 6: AXI slave ID width.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: asynchronous reset, active low.
- `up_id_i` in IdWidth: ID of the miss entering the pipeline.
- `up_rw_i` in 1: 0 read, 1 write.
- `up_valid_i` in 1: count-up request.
- `up_ready_o` out 1: count-up accepted; transfer when valid&ready.
- `down_id_i` in IdWidth: ID of the descriptor leaving (merge unit `cnt_down_o.id`).
- `down_rw_i` in 1: direction of the leaving descriptor (`cnt_down_o.rw`).
- `down_valid_i` in 1: count-down event (`cnt_down_o.valid`); no ready, always consumed.
- `query_id_i` in IdWidth: ID of the hit descriptor being checked.
- `query_rw_i` in 1: direction of the hit descriptor.
- `query_pending_o` out 1: a valid entry matches (query_id_i, query_rw_i).
- `busy_o` out 1: any entry valid.

## Operation
- Entry state: `valid`, `id`, `rw`, `cnt[CntWidth]`. Reset clears all fields to 0.
- Match means the entry is valid, its id equals the input ID, and its rw equals the input rw.
- Reads and writes with the same ID use independent entries.
- Count-up when a matching entry exists:
  - `cnt` increments.
  - `up_ready_o` = 0 while that entry's `cnt` is all-ones (saturation stall, no wrap).
- Count-up when no entry matches:
  - Allocate the lowest-index invalid entry with `cnt=1`.
  - `up_ready_o` = 0 when no entry is invalid.
- Count-down:
  - The matching entry's `cnt` decrements.
  - On reaching 0 the entry is invalidated.
  - Count-down with no match is a protocol error: no state change, simulation assertion fires.
- Same-entry up and down in one cycle: `cnt` unchanged, entry stays valid (including the `cnt==1` case).
- Down freeing entry k while an up needs a new allocation in the same cycle: allocation uses the registered invalid mask. Entry k is not reusable until the next cycle. If no other entry is free, `up_ready_o`=0.
- `up_ready_o` depends only on registered state and `up_id_i`/`up_rw_i`, never on `down_valid_i`. This avoids comb paths to the merge unit.
- `query_pending_o` and `busy_o` depend only on registered state. An up or down in the current cycle is not visible in the query; the query stays conservative.
- Implementer must not drop `up_valid_i` after asserting it without a handshake (AXI valid/ready rule); assertion required.

## Timing
- All outputs are 0 during reset, except `up_ready_o` = 1 (all entries free).
- Up/down take effect at the next rising edge; query reflects them one cycle later.
- `up_ready_o`, `query_pending_o` and `busy_o` are combinational from registers and the matching ID inputs. There are no input-to-output paths from `down_*`.
- Reset asserted mid-operation discards all counts immediately. The integrator guarantees the pipeline is also reset.

## Structure
- Entry struct `miss_cnt_entry_t` and the `cnt_t` layout (id, rw, valid) go in `axi_llc_pkg`, parameterised by width via the top's typedefs.
- Free-entry search uses one `lzc` instance (common_cells, `MODE=0`) on the invalid mask; its `empty_o` drives the "table full" condition.
- Match logic is an unrolled `NumCnt` compare; no further sub-modules.

## Test plan
- Reset, then up (id=3, rw=0) → next cycle `query_pending_o`=1 for (3,0) and 0 for (3,1); `busy_o`=1; down (3,0) → `busy_o`=0.
- Three ups (id=5, rw=1) then three downs → `cnt` 1,2,3,2,1,0; pending drops exactly after the third down.
- NumCnt=4: ups with IDs 1,2,3,4 then an up with id=7 → `up_ready_o`=0; down for id=2 → next cycle id=7 accepted into entry 1.
- Same cycle up+down on (9,0) with `cnt`=1 → entry stays valid, `cnt`=1, pending stays 1.
- CntWidth=2: three ups (4,0) → `up_ready_o`=0 for (4,0) while still 1 for (6,0).
- Reset asserted with 3 entries valid → all outputs at reset values within the same cycle; next up allocates entry 0.

Source files
------------

// File: rtl/axi_llc_miss_cnt_tracker_pkg.sv
// Shared types and helpers for the LLC miss-counter tracker.
// Width-dependent entry layouts are typedef'd in the top from its parameters.
package axi_llc_pkg;

  typedef enum logic {
    RW_READ  = 1'b0,
    RW_WRITE = 1'b1
  } rw_e;

  localparam int unsigned DefNumCnt   = 4;
  localparam int unsigned DefCntWidth = 4;
  localparam int unsigned DefIdWidth  = 6;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_llc_miss_cnt_tracker_lzc.sv
// Trailing (MODE=0) or leading (MODE=1) zero counter, same interface as common_cells lzc.
// empty_o flags an all-zero input; cnt_o is 0 in that case.
module axi_llc_miss_cnt_tracker_lzc #(
  parameter int unsigned WIDTH = 4,
  parameter bit          MODE  = 1'b0,
  localparam int unsigned CntWidth = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]    in_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic                empty_o
);

  // Scan from the far end so the position closest to the counted end wins.
  always_comb begin
    cnt_o = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (in_i[MODE ? (int'(WIDTH) - 1 - i) : i]) begin
        cnt_o = CntWidth'(i);
      end
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/axi_llc_miss_cnt_tracker.sv
// Per-(ID, direction) outstanding miss counters between the hit/miss and merge units.
// Outputs are combinational from registered state and the up/query IDs only.
module axi_llc_miss_cnt_tracker
  import axi_llc_pkg::*;
#(
  parameter int unsigned NumCnt   = DefNumCnt,
  parameter int unsigned CntWidth = DefCntWidth,
  parameter int unsigned IdWidth  = DefIdWidth
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [IdWidth-1:0] up_id_i,
  input  logic               up_rw_i,
  input  logic               up_valid_i,
  output logic               up_ready_o,
  input  logic [IdWidth-1:0] down_id_i,
  input  logic               down_rw_i,
  input  logic               down_valid_i,
  input  logic [IdWidth-1:0] query_id_i,
  input  logic               query_rw_i,
  output logic               query_pending_o,
  output logic               busy_o
);

  localparam int unsigned IdxWidth = idx_width(NumCnt);

  typedef logic [CntWidth-1:0] cnt_t;
  typedef logic [IdWidth-1:0]  id_t;

  typedef struct packed {
    logic valid;
    id_t  id;
    rw_e  rw;
    cnt_t cnt;
  } miss_cnt_entry_t;

  miss_cnt_entry_t entry_reg  [NumCnt];
  miss_cnt_entry_t entry_next [NumCnt];

  logic [NumCnt-1:0]   up_match;
  logic [NumCnt-1:0]   up_sat;
  logic [NumCnt-1:0]   down_match;
  logic [NumCnt-1:0]   query_match;
  logic [NumCnt-1:0]   invalid_mask;
  logic [IdxWidth-1:0] free_idx;
  logic                table_full;
  logic                up_hit;
  logic                up_fire;

  for (genvar gi = 0; gi < NumCnt; gi++) begin : g_match
    assign invalid_mask[gi] = ~entry_reg[gi].valid;
    assign up_match[gi]     = entry_reg[gi].valid && (entry_reg[gi].id == up_id_i)
                              && (entry_reg[gi].rw == rw_e'(up_rw_i));
    assign up_sat[gi]       = up_match[gi] && (&entry_reg[gi].cnt);
    assign down_match[gi]   = entry_reg[gi].valid && (entry_reg[gi].id == down_id_i)
                              && (entry_reg[gi].rw == rw_e'(down_rw_i));
    assign query_match[gi]  = entry_reg[gi].valid && (entry_reg[gi].id == query_id_i)
                              && (entry_reg[gi].rw == rw_e'(query_rw_i));
  end

  // Allocation sees only the registered invalid mask, so a same-cycle free is not reused.
  axi_llc_miss_cnt_tracker_lzc #(
    .WIDTH (NumCnt),
    .MODE  (1'b0)
  ) i_free_lzc (
    .in_i    (invalid_mask),
    .cnt_o   (free_idx),
    .empty_o (table_full)
  );

  assign up_hit          = |up_match;
  assign up_ready_o      = up_hit ? ~|up_sat : ~table_full;
  assign up_fire         = up_valid_i & up_ready_o;
  assign query_pending_o = |query_match;
  assign busy_o          = ~&invalid_mask;

  for (genvar gi = 0; gi < NumCnt; gi++) begin : g_entry
    logic inc, dec, alloc;

    assign inc   = up_fire & up_match[gi];
    assign dec   = down_valid_i & down_match[gi];
    assign alloc = up_fire & ~up_hit & ~table_full & (free_idx == IdxWidth'(gi));

    always_comb begin
      entry_next[gi] = entry_reg[gi];
      if (alloc) begin
        entry_next[gi].valid = 1'b1;
        entry_next[gi].id    = up_id_i;
        entry_next[gi].rw    = rw_e'(up_rw_i);
        entry_next[gi].cnt   = cnt_t'(1);
      end else if (inc && !dec) begin
        entry_next[gi].cnt = entry_reg[gi].cnt + cnt_t'(1);
      end else if (dec && !inc) begin
        entry_next[gi].cnt = entry_reg[gi].cnt - cnt_t'(1);
        if (entry_reg[gi].cnt == cnt_t'(1)) begin
          entry_next[gi].valid = 1'b0;
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        entry_reg[gi] <= '0;
      end else begin
        entry_reg[gi] <= entry_next[gi];
      end
    end
  end

`ifndef SYNTHESIS
  // A count-down must always correspond to a tracked miss.
  a_down_has_match: assert property (@(posedge clk_i) disable iff (!rst_ni)
    down_valid_i |-> |down_match);

  // A stalled count-up request must be held until accepted.
  a_up_valid_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (up_valid_i && !up_ready_o) |=> up_valid_i);
`endif

endmodule

// File: tb/tb_axi_llc_miss_cnt_tracker.sv
// Scoreboard bench for axi_llc_miss_cnt_tracker (NumCnt=4, CntWidth=2, IdWidth=6).
`timescale 1ns/1ps
module tb_axi_llc_miss_cnt_tracker;
  localparam int NumCnt   = 4;
  localparam int CntWidth = 2;
  localparam int IdWidth  = 6;

  localparam int KPend = 0;
  localparam int KBusy = 1;
  localparam int KCnt  = 2;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic [IdWidth-1:0] up_id_i = '0;
  logic               up_rw_i = 1'b0;
  logic               up_valid_i = 1'b0;
  logic               up_ready_o;
  logic [IdWidth-1:0] down_id_i = '0;
  logic               down_rw_i = 1'b0;
  logic               down_valid_i = 1'b0;
  logic [IdWidth-1:0] query_id_i = '0;
  logic               query_rw_i = 1'b0;
  logic               query_pending_o;
  logic               busy_o;

  int checks_cnt = 0;
  int errors_cnt = 0;

  typedef struct {
    string              tag;
    int                 kind;
    logic [IdWidth-1:0] id;
    logic               rw;
    int                 exp;
  } exp_t;

  exp_t sb_q[$];

  axi_llc_miss_cnt_tracker #(
    .NumCnt   (NumCnt),
    .CntWidth (CntWidth),
    .IdWidth  (IdWidth)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .up_id_i         (up_id_i),
    .up_rw_i         (up_rw_i),
    .up_valid_i      (up_valid_i),
    .up_ready_o      (up_ready_o),
    .down_id_i       (down_id_i),
    .down_rw_i       (down_rw_i),
    .down_valid_i    (down_valid_i),
    .query_id_i      (query_id_i),
    .query_rw_i      (query_rw_i),
    .query_pending_o (query_pending_o),
    .busy_o          (busy_o)
  );

  always #10 clk_i = ~clk_i;

  task automatic chk(input string tag, input int obs, input int exp);
    checks_cnt++;
    if (obs != exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  function automatic int dut_cnt(input logic [IdWidth-1:0] id, input logic rw);
    for (int i = 0; i < NumCnt; i++) begin
      if (dut.entry_reg[i].valid && dut.entry_reg[i].id == id && logic'(dut.entry_reg[i].rw) == rw)
        return int'(dut.entry_reg[i].cnt);
    end
    return 0;
  endfunction

  task automatic push(input string tag, input int kind, input int id, input logic rw, input int exp);
    exp_t e;
    e.tag = tag; e.kind = kind; e.id = IdWidth'(id); e.rw = rw; e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        KPend: begin
          query_id_i = e.id; query_rw_i = e.rw; #1;
          chk(e.tag, int'(query_pending_o), e.exp);
        end
        KBusy: chk(e.tag, int'(busy_o), e.exp);
        default: chk(e.tag, dut_cnt(e.id, e.rw), e.exp);
      endcase
    end
  endtask

  task automatic do_up(input int id, input logic rw, input string tag);
    up_id_i = IdWidth'(id); up_rw_i = rw; up_valid_i = 1'b1; #1;
    chk({tag, " ready"}, int'(up_ready_o), 1);
    @(posedge clk_i); #1;
    up_valid_i = 1'b0;
    drain();
  endtask

  task automatic do_down(input int id, input logic rw);
    down_id_i = IdWidth'(id); down_rw_i = rw; down_valid_i = 1'b1;
    @(posedge clk_i); #1;
    down_valid_i = 1'b0;
    drain();
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst busy", int'(busy_o), 0);
    chk("rst ready", int'(up_ready_o), 1);
    push("rst pend(3,0)", KPend, 3, 1'b0, 0);
    drain();
    rst_ni = 1'b1;

    // Single up/down and direction independence.
    push("t1 pend(3,0)", KPend, 3, 1'b0, 1);
    push("t1 pend(3,1)", KPend, 3, 1'b1, 0);
    push("t1 busy", KBusy, 0, 1'b0, 1);
    do_up(3, 1'b0, "t1 up");
    push("t1 busy after down", KBusy, 0, 1'b0, 0);
    push("t1 pend after down", KPend, 3, 1'b0, 0);
    do_down(3, 1'b0);

    // Counting up to three and back down.
    for (int k = 1; k <= 3; k++) begin
      push($sformatf("t2 cnt up%0d", k), KCnt, 5, 1'b1, k);
      push($sformatf("t2 pend up%0d", k), KPend, 5, 1'b1, 1);
      do_up(5, 1'b1, $sformatf("t2 up%0d", k));
    end
    for (int k = 2; k >= 0; k--) begin
      push($sformatf("t2 cnt down->%0d", k), KCnt, 5, 1'b1, k);
      push($sformatf("t2 pend down->%0d", k), KPend, 5, 1'b1, (k > 0) ? 1 : 0);
      do_down(5, 1'b1);
    end

    // Table full, then a freed slot becomes usable one cycle later.
    for (int id = 1; id <= 4; id++) do_up(id, 1'b0, $sformatf("t3 up id%0d", id));
    up_id_i = 6'd7; up_rw_i = 1'b0; up_valid_i = 1'b1; #1;
    chk("t3 full ready", int'(up_ready_o), 0);
    @(posedge clk_i); #1;
    chk("t3 held ready", int'(up_ready_o), 0);
    chk("t3 id7 not taken", dut_cnt(6'd7, 1'b0), 0);
    down_id_i = 6'd2; down_rw_i = 1'b0; down_valid_i = 1'b1; #1;
    chk("t3 ready ignores down", int'(up_ready_o), 0);
    @(posedge clk_i); #1;
    down_valid_i = 1'b0;
    chk("t3 freed ready", int'(up_ready_o), 1);
    @(posedge clk_i); #1;
    up_valid_i = 1'b0;
    chk("t3 entry1 id", int'(dut.entry_reg[1].id), 7);
    push("t3 pend(7,0)", KPend, 7, 1'b0, 1);
    push("t3 pend(2,0)", KPend, 2, 1'b0, 0);
    drain();
    do_down(1, 1'b0);
    do_down(3, 1'b0);
    do_down(4, 1'b0);
    push("t3 busy empty", KBusy, 0, 1'b0, 0);
    do_down(7, 1'b0);

    // Simultaneous up and down on a cnt==1 entry.
    do_up(9, 1'b0, "t4 up");
    push("t4 cnt", KCnt, 9, 1'b0, 1);
    push("t4 pend", KPend, 9, 1'b0, 1);
    up_id_i = 6'd9; up_rw_i = 1'b0; up_valid_i = 1'b1;
    do_down(9, 1'b0);
    up_valid_i = 1'b0;
    push("t4 busy empty", KBusy, 0, 1'b0, 0);
    do_down(9, 1'b0);

    // Saturation stalls only the saturated pair.
    for (int k = 1; k <= 3; k++) do_up(4, 1'b0, $sformatf("t5 up%0d", k));
    up_id_i = 6'd4; up_rw_i = 1'b0; #1;
    chk("t5 sat ready(4,0)", int'(up_ready_o), 0);
    up_id_i = 6'd6; #1;
    chk("t5 ready(6,0)", int'(up_ready_o), 1);
    do_down(4, 1'b0);
    do_down(4, 1'b0);
    push("t5 busy empty", KBusy, 0, 1'b0, 0);
    do_down(4, 1'b0);

    // Asynchronous reset with live entries.
    for (int id = 10; id <= 12; id++) do_up(id, 1'b0, $sformatf("t6 up id%0d", id));
    chk("t6 busy pre-rst", int'(busy_o), 1);
    @(negedge clk_i);
    rst_ni = 1'b0; #1;
    chk("t6 rst busy", int'(busy_o), 0);
    chk("t6 rst ready", int'(up_ready_o), 1);
    push("t6 rst pend(11,0)", KPend, 11, 1'b0, 0);
    drain();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    push("t6 pend(8,1)", KPend, 8, 1'b1, 1);
    push("t6 busy", KBusy, 0, 1'b0, 1);
    do_up(8, 1'b1, "t6 up");
    chk("t6 entry0 id", int'(dut.entry_reg[0].id), 8);
    chk("t6 entry1 valid", int'(dut.entry_reg[1].valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
